// File: rtl/jk_seq_pkg.sv
// Package shared by the JK bank sequencer and its testbench.
// Holds the command opcodes, the sequencer FSM state encoding and the
// per-bit decode from a (command, mask bit) pair to the bank's J/K pair.
package jk_seq_pkg;

  // Command opcodes as presented on req_op
  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_CLR  = 2'b01;
  localparam logic [1:0] OP_SET  = 2'b10;
  localparam logic [1:0] OP_TGL  = 2'b11;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DRIVE  = 2'b01,
    SETTLE = 2'b10
  } seq_state_t;

  // Decode one bank bit: returns {j, k}. An unmasked bit is left alone
  // (j=k=0, which a JK flop treats as hold).
  function automatic logic [1:0] jk_decode(input logic [1:0] op, input logic mask_bit);
    logic [1:0] jk;
    jk = 2'b00;
    if (mask_bit) begin
      case (op)
        OP_HOLD: jk = 2'b00;
        OP_CLR:  jk = 2'b01;
        OP_SET:  jk = 2'b10;
        OP_TGL:  jk = 2'b11;
        default: jk = 2'b00;
      endcase
    end
    return jk;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purely combinational round-robin arbiter.
// Ports:
//   req   - request vector, one bit per requester
//   ptr   - index where the search starts (highest priority); wraps modulo N
//   grant - one-hot grant of the first requester found from ptr, or all zero
//   idx   - binary index of the granted requester (0 when nothing is granted)
// The pointer register itself lives in the instantiating sequencer.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  // Walk the requesters starting at ptr and wrapping; the first asserted
  // request wins. cand carries one extra bit so ptr+k cannot overflow
  // before the modulo-N wrap is applied.
  always_comb begin
    logic [IW:0]   cand;
    logic [IW-1:0] cand_idx;
    logic          found;
    grant    = '0;
    idx      = '0;
    found    = 1'b0;
    cand     = '0;
    cand_idx = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) begin
        cand = cand - (IW+1)'(N);
      end
      cand_idx = cand[IW-1:0];
      if (!found && req[cand_idx]) begin
        found           = 1'b1;
        grant[cand_idx] = 1'b1;
        idx             = cand_idx;
      end
    end
  end

endmodule

// File: rtl/jk_bank_sequencer.sv
// Round-robin command sequencer in front of a shared bank of master-slave
// JK flip-flops. One requester is granted at a time; its hold/clear/set/
// toggle command is applied to the masked bits for exactly one capture
// edge, the slave stage is given a cycle to settle, and the resulting Q
// is handed back with the requester's index.
// Ports:
//   clk        - rising-edge clock for all state in this block
//   reset      - asynchronous active-high clear
//   req_valid  - per-requester command valid
//   req_op     - per-requester opcode, requester i at [2i+1:2i]
//   req_mask   - per-requester bit mask, requester i at [WIDTH*i +: WIDTH]
//   req_ready  - one-hot accept, only in IDLE
//   j_out      - J inputs of the bank (nonzero only in DRIVE)
//   k_out      - K inputs of the bank (nonzero only in DRIVE)
//   q_in       - slave Q outputs of the bank
//   done_valid - single-cycle completion pulse
//   done_id    - requester index of the completed command
//   done_q     - bank Q sampled at the end of SETTLE
//   busy       - high while in DRIVE or SETTLE
module jk_bank_sequencer
  import jk_seq_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [2*NREQ-1:0]        req_op,
  input  logic [WIDTH*NREQ-1:0]    req_mask,
  output logic [NREQ-1:0]          req_ready,
  output logic [WIDTH-1:0]         j_out,
  output logic [WIDTH-1:0]         k_out,
  input  logic [WIDTH-1:0]         q_in,
  output logic                     done_valid,
  output logic [$clog2(NREQ)-1:0]  done_id,
  output logic [WIDTH-1:0]         done_q,
  output logic                     busy
);

  localparam int IDX_W = $clog2(NREQ);

  seq_state_t       state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] cmd_id;
  logic [IDX_W-1:0] win_idx;
  logic [NREQ-1:0]  win_grant;
  logic [1:0]       win_op;
  logic [WIDTH-1:0] win_mask;
  logic [WIDTH-1:0] drive_j;
  logic [WIDTH-1:0] drive_k;
  logic             handshake;
  logic [IDX_W-1:0] ptr_next;

  // Winner selection is combinational from req_valid and the pointer.
  rr_arbiter #(
    .N  (NREQ),
    .IW (IDX_W)
  ) u_arbiter (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (win_grant),
    .idx   (win_idx)
  );

  // Grants are only offered while idle; reset is folded in so that ready
  // reads zero for the whole time reset is held, even with requests pending.
  assign req_ready = (state == IDLE && !reset) ? win_grant : '0;
  assign handshake = |(req_valid & req_ready);

  // Pointer moves one past the winner so the winner gets lowest priority
  // on the next round.
  assign ptr_next = (win_idx == IDX_W'(NREQ - 1)) ? '0 : win_idx + IDX_W'(1);

  // Pull the winner's command out of the packed request buses and decode
  // it into the J/K pattern that is registered on the handshake edge, so
  // the bank sees it throughout DRIVE.
  always_comb begin
    win_op   = req_op[2*int'(win_idx) +: 2];
    win_mask = req_mask[WIDTH*int'(win_idx) +: WIDTH];
    drive_j  = '0;
    drive_k  = '0;
    for (int b = 0; b < WIDTH; b++) begin
      {drive_j[b], drive_k[b]} = jk_decode(win_op, win_mask[b]);
    end
  end

  // Main sequencer FSM. IDLE accepts a command and registers its J/K
  // pattern; DRIVE holds that pattern for the bank's single capture edge;
  // SETTLE zeroes J/K and waits for the falling-edge slave update, then
  // samples q_in on the edge that returns to IDLE. done_valid defaults low
  // every cycle so it can only ever be a one-cycle pulse, and a reset
  // mid-command simply drops everything without reporting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= '0;
      cmd_id     <= '0;
      j_out      <= '0;
      k_out      <= '0;
      done_valid <= 1'b0;
      done_id    <= '0;
      done_q     <= '0;
      busy       <= 1'b0;
    end else begin
      done_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (handshake) begin
            cmd_id <= win_idx;
            ptr    <= ptr_next;
            j_out  <= drive_j;
            k_out  <= drive_k;
            busy   <= 1'b1;
            state  <= DRIVE;
          end
        end
        DRIVE: begin
          j_out <= '0;
          k_out <= '0;
          state <= SETTLE;
        end
        SETTLE: begin
          done_q     <= q_in;
          done_id    <= cmd_id;
          done_valid <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          j_out <= '0;
          k_out <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Testbench for jk_bank_sequencer: a JK bank built next to the DUT, a
// behavioural model of the bank contents and the round-robin order, and a
// directed sequence followed by randomized traffic.
module tb_jk_bank_sequencer;
  import jk_seq_pkg::*;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                    clk;
  logic                    reset;
  logic [NREQ-1:0]         req_valid;
  logic [2*NREQ-1:0]       req_op;
  logic [WIDTH*NREQ-1:0]   req_mask;
  logic [NREQ-1:0]         req_ready;
  logic [WIDTH-1:0]        j_out;
  logic [WIDTH-1:0]        k_out;
  logic [WIDTH-1:0]        q_in;
  logic                    done_valid;
  logic [1:0]              done_id;
  logic [WIDTH-1:0]        done_q;
  logic                    busy;

  logic [1:0]       op_arr   [NREQ];
  logic [WIDTH-1:0] mask_arr [NREQ];

  int checks_total;
  int checks_passed;
  int checks_failed;

  logic [WIDTH-1:0] exp_q;
  int               exp_ptr;

  assign req_op   = {op_arr[3], op_arr[2], op_arr[1], op_arr[0]};
  assign req_mask = {mask_arr[3], mask_arr[2], mask_arr[1], mask_arr[0]};

  jk_bank_sequencer #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_mask   (req_mask),
    .req_ready  (req_ready),
    .j_out      (j_out),
    .k_out      (k_out),
    .q_in       (q_in),
    .done_valid (done_valid),
    .done_id    (done_id),
    .done_q     (done_q),
    .busy       (busy)
  );

  // Master-slave JK bank: master captures from J/K and the current slave
  // on the rising edge, slave copies the master on the falling edge.
  logic [WIDTH-1:0] bank_m;
  logic [WIDTH-1:0] bank_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) bank_m <= '0;
    else       bank_m <= (j_out & ~bank_q) | (~k_out & bank_q);
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) bank_q <= '0;
    else       bank_q <= bank_m;
  end

  assign q_in = bank_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case anything ever stalls the main sequence.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Effect of a command on the bank as a whole-word operation.
  function automatic logic [WIDTH-1:0] model_apply(input logic [WIDTH-1:0] q,
                                                   input logic [1:0] op,
                                                   input logic [WIDTH-1:0] m);
    case (op)
      OP_SET:  return q | m;
      OP_CLR:  return q & ~m;
      OP_TGL:  return q ^ m;
      default: return q;
    endcase
  endfunction

  // First valid requester at or after ptr, wrapping; -1 when none.
  function automatic int model_winner(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks_total++;
    assert (observed === expected) begin
      checks_passed++;
    end else begin
      checks_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One full command: check the grant, walk DRIVE and SETTLE, check the
  // completion. Entered and left at posedge+1 of an IDLE cycle.
  task automatic applyStimulus(input bit keep, input logic [NREQ-1:0] raise_in_settle,
                               output int granted);
    int               w;
    logic [1:0]       op;
    logic [WIDTH-1:0] mk;
    logic [WIDTH-1:0] exp_j;
    logic [WIDTH-1:0] exp_k;
    logic [WIDTH-1:0] q_next;
    #1;
    w = model_winner(req_valid, exp_ptr);
    granted = w;
    if (w < 0) begin
      checkOutput("winner_exists", 32'(req_ready), 32'hFFFF_FFFF);
      return;
    end
    checkOutput("ready_grant", 32'(req_ready), 32'(1) << w);
    op     = op_arr[w];
    mk     = mask_arr[w];
    exp_j  = (op == OP_SET || op == OP_TGL) ? mk : '0;
    exp_k  = (op == OP_CLR || op == OP_TGL) ? mk : '0;
    q_next = model_apply(exp_q, op, mk);
    tick();
    if (!keep) req_valid[w] = 1'b0;
    exp_ptr = (w + 1) % NREQ;
    checkOutput("drive_busy", 32'(busy), 32'd1);
    checkOutput("drive_ready", 32'(req_ready), 32'd0);
    checkOutput("drive_j", 32'(j_out), 32'(exp_j));
    checkOutput("drive_k", 32'(k_out), 32'(exp_k));
    checkOutput("drive_done", 32'(done_valid), 32'd0);
    tick();
    checkOutput("settle_j", 32'(j_out), 32'd0);
    checkOutput("settle_k", 32'(k_out), 32'd0);
    checkOutput("settle_busy", 32'(busy), 32'd1);
    checkOutput("settle_done", 32'(done_valid), 32'd0);
    req_valid = req_valid | raise_in_settle;
    #1;
    checkOutput("settle_ready", 32'(req_ready), 32'd0);
    tick();
    checkOutput("done_valid", 32'(done_valid), 32'd1);
    checkOutput("done_id", 32'(done_id), 32'(w));
    checkOutput("done_q", 32'(done_q), 32'(q_next));
    checkOutput("done_busy", 32'(busy), 32'd0);
    exp_q = q_next;
  endtask

  // A cycle with nothing requested: no grant and no repeated done pulse.
  task automatic idleCycle();
    tick();
    checkOutput("idle_ready", 32'(req_ready), 32'd0);
    checkOutput("idle_done", 32'(done_valid), 32'd0);
    checkOutput("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int g;
    int expected_order [5];
    checks_total  = 0;
    checks_passed = 0;
    checks_failed = 0;
    exp_q         = '0;
    exp_ptr       = 0;
    req_valid     = '0;
    for (int i = 0; i < NREQ; i++) begin
      op_arr[i]   = OP_HOLD;
      mask_arr[i] = '0;
    end
    expected_order = '{0, 1, 2, 3, 0};

    // Reset values
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_j", 32'(j_out), 32'd0);
    checkOutput("rst_k", 32'(k_out), 32'd0);
    checkOutput("rst_done_valid", 32'(done_valid), 32'd0);
    checkOutput("rst_done_id", 32'(done_id), 32'd0);
    checkOutput("rst_done_q", 32'(done_q), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick();

    // Requester 0: set 0F
    op_arr[0] = OP_SET; mask_arr[0] = 8'h0F; req_valid = 4'b0001;
    applyStimulus(1'b0, '0, g);
    checkOutput("t1_id", 32'(g), 32'd0);
    checkOutput("t1_q", 32'(done_q), 32'h0F);
    idleCycle();

    // Requester 2: toggle FF, then clear 30 back-to-back
    op_arr[2] = OP_TGL; mask_arr[2] = 8'hFF; req_valid = 4'b0100;
    applyStimulus(1'b0, '0, g);
    checkOutput("t2_tgl_q", 32'(done_q), 32'hF0);
    op_arr[2] = OP_CLR; mask_arr[2] = 8'h30; req_valid = 4'b0100;
    applyStimulus(1'b0, '0, g);
    checkOutput("t2_clr_q", 32'(done_q), 32'hC0);

    // Build A5, then hold with full mask
    op_arr[1] = OP_CLR; mask_arr[1] = 8'hFF; req_valid = 4'b0010;
    applyStimulus(1'b0, '0, g);
    op_arr[1] = OP_SET; mask_arr[1] = 8'hA5; req_valid = 4'b0010;
    applyStimulus(1'b0, '0, g);
    op_arr[1] = OP_HOLD; mask_arr[1] = 8'hFF; req_valid = 4'b0010;
    applyStimulus(1'b0, '0, g);
    checkOutput("hold_q", 32'(done_q), 32'hA5);
    idleCycle();

    // Reset during DRIVE aborts the command
    op_arr[1] = OP_TGL; mask_arr[1] = 8'hFF; req_valid = 4'b0010;
    tick();
    checkOutput("abort_drive_busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("abort_j", 32'(j_out), 32'd0);
    checkOutput("abort_k", 32'(k_out), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_ready", 32'(req_ready), 32'd0);
    checkOutput("abort_done", 32'(done_valid), 32'd0);
    checkOutput("abort_bank", 32'(q_in), 32'd0);
    req_valid = '0;
    tick();
    reset = 1'b0;
    exp_q   = '0;
    exp_ptr = 0;
    for (int i = 0; i < 3; i++) begin
      idleCycle();
    end

    // All four continuously valid from pointer 0; requester 0 toggles
    // everything so its result also exposes the cleared bank.
    op_arr[0] = OP_TGL; mask_arr[0] = 8'hFF;
    for (int i = 1; i < NREQ; i++) begin
      op_arr[i]   = 2'($urandom_range(0, 3));
      mask_arr[i] = 8'($urandom);
    end
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, '0, g);
      checkOutput("rr_order", 32'(g), 32'(expected_order[i]));
      if (i == 0) checkOutput("post_reset_q", 32'(done_q), 32'hFF);
    end
    req_valid = '0;
    idleCycle();

    // Only requester 3, with requester 1 arriving during SETTLE
    req_valid = 4'b1000;
    applyStimulus(1'b0, 4'b0010, g);
    checkOutput("late_first", 32'(g), 32'd3);
    applyStimulus(1'b0, '0, g);
    checkOutput("late_second", 32'(g), 32'd1);
    idleCycle();

    // Randomized traffic against the model
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i]) begin
          op_arr[i]   = 2'($urandom_range(0, 3));
          mask_arr[i] = 8'($urandom);
        end
      end
      if ($urandom_range(0, 3) == 0) begin
        req_valid = '0;
        idleCycle();
      end
      req_valid = req_valid | 4'($urandom);
      if (req_valid == '0) req_valid[$urandom_range(0, NREQ - 1)] = 1'b1;
      applyStimulus(1'b0, '0, g);
    end
    req_valid = '0;
    idleCycle();

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/jk_bank_sequencer.md
# jk_bank_sequencer

Round-robin command sequencer sharing one bank of WIDTH master-slave JK flip-flops (master captures on rising clk, slave follows on falling clk, both cleared by reset) among NREQ requesters. Each requester submits a hold/clear/set/toggle command with a per-bit mask. The block grants one requester at a time and drives the bank's J/K inputs for exactly one capture edge. It waits for the slave stage to settle, then returns the bank's resulting Q to the winner. The block sits between the requester logic and the JK bank; the bank's reset is tied to the same reset.

## Interface
- NREQ, default 4: number of requesters (2..8).
- WIDTH, default 8: bits in the JK bank.

- clk  in  1  sole clock; rising edge for all state in this block.
- reset  in  1  asynchronous, active-high; clears all state.
- req_valid  in  NREQ  per-requester command valid.
- req_op  in  2*NREQ  command for requester i at [2i+1:2i]: 00 hold, 01 clear, 10 set, 11 toggle.
- req_mask  in  WIDTH*NREQ  bits to affect for requester i at [WIDTH*i +: WIDTH].
- req_ready  out  NREQ  one-hot grant/accept; handshake when req_valid[i] & req_ready[i] at a rising edge.
- j_out  out  WIDTH  J inputs to the bank.
- k_out  out  WIDTH  K inputs to the bank.
- q_in  in  WIDTH  slave Q outputs of the bank.
- done_valid  out  1  one-cycle pulse: command complete.
- done_id  out  $clog2(NREQ)  requester index of the completed command.
- done_q  out  WIDTH  bank Q sampled after the command.
- busy  out  1  high in DRIVE and SETTLE.

## Operation
- FSM states:
  - IDLE: req_ready is one-hot on the round-robin winner among asserted req_valid; it is all-zero if none are asserted. The winner is combinational from req_valid and the registered pointer. On handshake, latch op, mask, and index, then go to DRIVE.
  - DRIVE: drive j_out/k_out from the latched command for exactly one cycle, then go to SETTLE.
  - SETTLE: j_out = k_out = 0. At the rising edge ending SETTLE, register done_q <= q_in, done_id <= latched index, and done_valid <= 1. Return to IDLE.
- Decode per bit b:
  - mask[b]=0 gives j=k=0.
  - mask[b]=1 gives: hold 0/0, clear 0/1, set 1/0, toggle 1/1 (j/k).
- j_out and k_out are registered and are 0 in every state except DRIVE.
- Round-robin: on handshake, pointer <= winner+1 (mod NREQ). The search starts at pointer and wraps.
- req_ready is 0 in DRIVE and SETTLE. Requests held across those states are not lost; requesters keep valid asserted until accepted.
- Reset values: state IDLE, pointer 0, j_out/k_out 0, req_ready 0, done_valid 0, done_id 0, done_q 0, busy 0.
- Reset mid-operation aborts the command with no done pulse. The bank is cleared by the same reset.
- The hold op with any mask still runs the full sequence and reports Q.

## Timing
- Cycle A (IDLE, handshake edge) → cycle A+1 DRIVE: J/K valid; bank master captures at the edge ending A+1.
- Cycle A+2 SETTLE: slave updates at the falling edge mid-cycle. q_in is stable by the rising edge ending A+2.
- Cycle A+3: done_valid=1 with done_q/done_id. This cycle is IDLE, so a new handshake may occur in the same cycle.
- Sustained throughput: one command per 3 cycles.
- Latency from handshake edge to done_valid: 3 cycles.
- done_valid is a single-cycle pulse. It is never asserted in two consecutive cycles.

## Structure
- Package jk_seq_pkg holds:
  - op localparams: OP_HOLD=2'b00, OP_CLR=2'b01, OP_SET=2'b10, OP_TGL=2'b11.
  - FSM state encoding: IDLE, DRIVE, SETTLE.
  - A decode function (op, mask) → {j, k}.
- One sub-module, rr_arbiter (parameter N): inputs req, ptr; output one-hot grant plus index. It is purely combinational; the pointer register lives in the sequencer.
- The testbench instantiates the JK bank (WIDTH master-slave flops) next to the block and connects j_out/k_out/q_in.

## Test plan
- Reset, then requester 0 sends set with mask 8'h0F → j_out=8'h0F, k_out=0 in DRIVE only; done_valid 3 cycles after handshake; done_q=8'h0F, done_id=0.
- From Q=8'h0F, requester 2 sends toggle with mask 8'hFF → done_q=8'hF0. Then clear with mask 8'h30 → done_q=8'hC0.
- All 4 requesters valid continuously from pointer 0 → grants in order 0,1,2,3,0. Handshakes land exactly 3 cycles apart; no requester is granted twice before all others.
- Only requester 3 valid, then requester 1 raised during SETTLE → req_ready stays 0 until IDLE. Requester 1 is granted at the next IDLE, since the pointer wrapped to 0 and 1 wins.
- Assert reset during DRIVE → all outputs 0 asynchronously; no done_valid; the next command after reset sees bank Q=0.
- Hold op with mask 8'hFF on Q=8'hA5 → j_out=k_out=0 throughout; done_q=8'hA5 after 3 cycles.
